// File: rtl/alu_result_framer_if.sv
// Result/transmit bundle between the arithmetic unit, the result framer and the UART transmitter.
// The framer takes the slave view; whoever drives results and TX_BUSY takes the master view.
`timescale 1ns/1ps
interface alu_result_framer_if #(
    parameter int unsigned ARITH_WIDTH = 10
);
    logic [ARITH_WIDTH-1:0] ARITH_OUT;
    logic                   CARRY_OUT;
    logic                   ARITH_FLAG;
    logic                   TX_BUSY;
    logic [7:0]             TX_DATA;
    logic                   TX_VALID;
    logic                   FRAME_BUSY;
    logic [7:0]             DROP_CNT;

    modport master (
        output ARITH_OUT, CARRY_OUT, ARITH_FLAG, TX_BUSY,
        input  TX_DATA, TX_VALID, FRAME_BUSY, DROP_CNT
    );

    modport slave (
        input  ARITH_OUT, CARRY_OUT, ARITH_FLAG, TX_BUSY,
        output TX_DATA, TX_VALID, FRAME_BUSY, DROP_CNT
    );
endinterface

// File: rtl/alu_result_framer.sv
// Packs each flagged arithmetic result into a header / LSB-first data / XOR-checksum byte frame
// and streams it to the UART transmitter, with one result of buffering while a frame is in flight.
`timescale 1ns/1ps
module alu_result_framer #(
    parameter int unsigned ARITH_WIDTH = 10,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    alu_result_framer_if.slave bus
);

    localparam int unsigned NUM_BYTES = (ARITH_WIDTH + 1 + 7) / 8;
    localparam int unsigned WORD_W    = NUM_BYTES * 8;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [7:0]  DROP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_CSUM = 2'd3
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_frame;
    logic [WORD_W-1:0]   r_pend;
    logic                r_pend_full;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_frame_busy;
    logic [7:0]          r_drop_cnt;

    logic [WORD_W-1:0]   w_in_word;
    logic                w_accept;
    logic                w_frame_done;
    logic [7:0]          w_csum;

    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] word, input int unsigned k);
        return 8'(word >> (8 * k));
    endfunction

    assign w_in_word    = WORD_W'({bus.CARRY_OUT, bus.ARITH_OUT});
    assign w_accept     = r_tx_valid & ~bus.TX_BUSY;
    assign w_frame_done = w_accept & (r_state == S_CSUM);

    // Checksum of the frame currently held; only consumed on the last data-byte accept.
    always_comb begin
        w_csum = HDR_BYTE;
        for (int unsigned k = 0; k < NUM_BYTES; k++) begin
            w_csum = w_csum ^ get_byte(r_frame, k);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= S_IDLE;
            r_frame      <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_idx        <= '0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_frame_busy <= 1'b0;
            r_drop_cnt   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ARITH_FLAG) begin
                        r_frame      <= w_in_word;
                        r_state      <= S_HDR;
                        r_tx_data    <= HDR_BYTE;
                        r_tx_valid   <= 1'b1;
                        r_frame_busy <= 1'b1;
                    end
                end

                default: begin
                    if (w_frame_done) begin
                        // Frame complete: chain straight into the next result if one exists.
                        if (r_pend_full) begin
                            r_frame     <= r_pend;
                            r_state     <= S_HDR;
                            r_tx_data   <= HDR_BYTE;
                            r_pend_full <= bus.ARITH_FLAG;
                            if (bus.ARITH_FLAG) begin
                                r_pend <= w_in_word;
                            end
                        end else if (bus.ARITH_FLAG) begin
                            r_frame   <= w_in_word;
                            r_state   <= S_HDR;
                            r_tx_data <= HDR_BYTE;
                        end else begin
                            r_state      <= S_IDLE;
                            r_tx_data    <= 8'h00;
                            r_tx_valid   <= 1'b0;
                            r_frame_busy <= 1'b0;
                        end
                    end else begin
                        if (w_accept) begin
                            case (r_state)
                                S_HDR: begin
                                    r_idx     <= '0;
                                    r_state   <= S_DATA;
                                    r_tx_data <= get_byte(r_frame, 0);
                                end
                                S_DATA: begin
                                    if (r_idx == LAST_IDX) begin
                                        r_state   <= S_CSUM;
                                        r_tx_data <= w_csum;
                                    end else begin
                                        r_idx     <= r_idx + IDX_W'(1);
                                        r_tx_data <= get_byte(r_frame, 32'(r_idx) + 32'd1);
                                    end
                                end
                                default: begin
                                    r_state <= r_state;
                                end
                            endcase
                        end

                        // Mid-frame arrivals: buffer one, count the rest as drops.
                        if (bus.ARITH_FLAG) begin
                            if (!r_pend_full) begin
                                r_pend      <= w_in_word;
                                r_pend_full <= 1'b1;
                            end else if (r_drop_cnt != DROP_MAX) begin
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.TX_DATA    = r_tx_data;
    assign bus.TX_VALID   = r_tx_valid;
    assign bus.FRAME_BUSY = r_frame_busy;
    assign bus.DROP_CNT   = r_drop_cnt;

endmodule

// File: tb/tb_alu_result_framer.sv
// Scoreboard bench for alu_result_framer: expected frame bytes are queued when a result is driven
// and checked against every byte the transmitter accepts.
`timescale 1ns/1ps
module tb_alu_result_framer;

    localparam int unsigned AW  = 10;
    localparam logic [7:0]  HDR = 8'hA5;

    logic CLK;
    logic RST;

    alu_result_framer_if #(.ARITH_WIDTH(AW)) bus_if ();

    alu_result_framer #(.ARITH_WIDTH(AW), .HDR_BYTE(HDR)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  exp_b;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Independent frame model: header, {carry,result} bytes LSB-first, XOR checksum.
    task automatic push_frame(input logic [AW-1:0] a, input logic c);
        logic [15:0] w;
        w = {5'b0, c, a};
        exp_q.push_back(HDR);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(HDR ^ w[7:0] ^ w[15:8]);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic c, input logic flag);
        bus_if.ARITH_OUT  = a;
        bus_if.CARRY_OUT  = c;
        bus_if.ARITH_FLAG = flag;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus_if.FRAME_BUSY === 1'b0 && bus_if.TX_VALID === 1'b0 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Byte monitor: each accepted byte pops the scoreboard; stalled bytes must hold.
    always @(negedge CLK) begin
        if (mon_en && RST === 1'b1) begin
            if (prev_stall) begin
                n_cmp++;
                if (bus_if.TX_VALID !== 1'b1 || bus_if.TX_DATA !== prev_data) begin
                    n_err++;
                    $display("FAIL hold_stable: got valid=%b data=%h, expected valid=1 data=%h",
                             bus_if.TX_VALID, bus_if.TX_DATA, prev_data);
                end
            end
            if (bus_if.TX_VALID === 1'b1 && bus_if.TX_BUSY === 1'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_byte: got unexpected byte %h, expected no byte", bus_if.TX_DATA);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus_if.TX_DATA !== exp_b) begin
                        n_err++;
                        $display("FAIL tx_byte: got %h, expected %h", bus_if.TX_DATA, exp_b);
                    end
                end
            end
            prev_stall = (bus_if.TX_VALID === 1'b1 && bus_if.TX_BUSY === 1'b1);
            prev_data  = bus_if.TX_DATA;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic test_reset();
        RST = 1'b0;
        drive(10'h000, 1'b0, 1'b0);
        bus_if.TX_BUSY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b0 || bus_if.TX_DATA !== 8'h00 ||
            bus_if.FRAME_BUSY !== 1'b0 || bus_if.DROP_CNT !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b data=%h busy=%b drop=%h, expected 0/00/0/00",
                     bus_if.TX_VALID, bus_if.TX_DATA, bus_if.FRAME_BUSY, bus_if.DROP_CNT);
        end
        RST    = 1'b1;
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus_if.TX_BUSY = 1'b0;
        drive(10'h2F3, 1'b1, 1'b1);
        push_frame(10'h2F3, 1'b1);
        step();
        bus_if.ARITH_FLAG = 1'b0;
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b1 || bus_if.TX_DATA !== HDR) begin
            n_err++;
            $display("FAIL basic_latency: got valid=%b data=%h, expected valid=1 data=a5",
                     bus_if.TX_VALID, bus_if.TX_DATA);
        end
        repeat (3) step();
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b1 || bus_if.TX_DATA !== 8'h50) begin
            n_err++;
            $display("FAIL basic_csum: got valid=%b data=%h, expected valid=1 data=50",
                     bus_if.TX_VALID, bus_if.TX_DATA);
        end
        step();
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b0 || bus_if.FRAME_BUSY !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL basic_idle: got valid=%b busy=%b left=%0d, expected 0/0/0",
                     bus_if.TX_VALID, bus_if.FRAME_BUSY, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bus_if.TX_BUSY = 1'b1;
        drive(10'h2F3, 1'b1, 1'b1);
        push_frame(10'h2F3, 1'b1);
        step();
        bus_if.ARITH_FLAG = 1'b0;
        for (int b = 0; b < 4; b++) begin
            repeat (5) step();
            bus_if.TX_BUSY = 1'b0;
            step();
            bus_if.TX_BUSY = 1'b1;
        end
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b0 || bus_if.FRAME_BUSY !== 1'b0 ||
            bus_if.DROP_CNT !== 8'h00 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL backpressure_end: got valid=%b busy=%b drop=%h left=%0d, expected 0/0/00/0",
                     bus_if.TX_VALID, bus_if.FRAME_BUSY, bus_if.DROP_CNT, exp_q.size());
        end
        bus_if.TX_BUSY = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nvalid;
        int last_hi;
        nvalid  = 0;
        last_hi = -1;
        bus_if.TX_BUSY = 1'b0;
        drive(10'h001, 1'b0, 1'b1);
        push_frame(10'h001, 1'b0);
        step();
        bus_if.ARITH_FLAG = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                drive(10'h3FF, 1'b0, 1'b1);
                push_frame(10'h3FF, 1'b0);
            end
            if (i == 2) bus_if.ARITH_FLAG = 1'b0;
            if (bus_if.TX_VALID === 1'b1) begin
                nvalid++;
                last_hi = i;
            end
            step();
        end
        n_cmp++;
        if (nvalid != 8 || last_hi != 7) begin
            n_err++;
            $display("FAIL b2b_no_gap: got %0d valid cycles ending at %0d, expected 8 ending at 7",
                     nvalid, last_hi);
        end
        n_cmp++;
        if (exp_q.size() != 0 || bus_if.FRAME_BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: got left=%0d busy=%b, expected 0/0", exp_q.size(), bus_if.FRAME_BUSY);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        bus_if.TX_BUSY = 1'b0;
        drive(10'h155, 1'b0, 1'b1);
        push_frame(10'h155, 1'b0);
        step();
        bus_if.ARITH_FLAG = 1'b0;
        repeat (3) step();
        drive(10'h2AA, 1'b1, 1'b1);
        push_frame(10'h2AA, 1'b1);
        step();
        bus_if.ARITH_FLAG = 1'b0;
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b1 || bus_if.TX_DATA !== HDR) begin
            n_err++;
            $display("FAIL simul_restart: got valid=%b data=%h, expected valid=1 data=a5",
                     bus_if.TX_VALID, bus_if.TX_DATA);
        end
        wait_idle(20, ok);
        n_cmp++;
        if (!ok || bus_if.DROP_CNT !== 8'h00) begin
            n_err++;
            $display("FAIL simul_end: got idle=%b drop=%h left=%0d, expected idle=1 drop=00 left=0",
                     ok, bus_if.DROP_CNT, exp_q.size());
        end
    endtask

    task automatic test_drop_saturate();
        bit ok;
        bus_if.TX_BUSY = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(10'(i * 37 + 5), i[0], 1'b1);
            if (i < 2) push_frame(10'(i * 37 + 5), i[0]);
            step();
        end
        bus_if.ARITH_FLAG = 1'b0;
        n_cmp++;
        if (bus_if.DROP_CNT !== 8'hFF || bus_if.FRAME_BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL drop_sat: got drop=%h busy=%b, expected drop=ff busy=1",
                     bus_if.DROP_CNT, bus_if.FRAME_BUSY);
        end
        step();
        bus_if.TX_BUSY = 1'b0;
        wait_idle(40, ok);
        n_cmp++;
        if (!ok || bus_if.DROP_CNT !== 8'hFF) begin
            n_err++;
            $display("FAIL drop_drain: got idle=%b drop=%h left=%0d, expected idle=1 drop=ff left=0",
                     ok, bus_if.DROP_CNT, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus_if.TX_BUSY = 1'b0;
        drive(10'h0F0, 1'b1, 1'b1);
        push_frame(10'h0F0, 1'b1);
        step();
        bus_if.ARITH_FLAG = 1'b0;
        step();
        #1;
        mon_en = 1'b0;
        RST    = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b0 || bus_if.DROP_CNT !== 8'h00 ||
            bus_if.FRAME_BUSY !== 1'b0 || bus_if.TX_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async: got valid=%b drop=%h busy=%b data=%h, expected 0/00/0/00",
                     bus_if.TX_VALID, bus_if.DROP_CNT, bus_if.FRAME_BUSY, bus_if.TX_DATA);
        end
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST    = 1'b1;
        mon_en = 1'b1;
        step();
        drive(10'h155, 1'b1, 1'b1);
        push_frame(10'h155, 1'b1);
        step();
        bus_if.ARITH_FLAG = 1'b0;
        n_cmp++;
        if (bus_if.TX_VALID !== 1'b1 || bus_if.TX_DATA !== HDR) begin
            n_err++;
            $display("FAIL reset_fresh: got valid=%b data=%h, expected valid=1 data=a5",
                     bus_if.TX_VALID, bus_if.TX_DATA);
        end
        wait_idle(20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL reset_drain: got idle=0 left=%0d, expected idle=1 left=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_drop_saturate();
        test_reset_mid();
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, expected completion");
        $fatal(1);
    end

endmodule
